// File: rtl/mc_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mc_muldiv_unit
// Iterative multiply/divide unit with HI/LO result registers for the
// multicycle datapath. One result bit per cycle through a shared
// shift-add (multiply) / restoring-subtract (divide) engine.
//
// Optional feature macro: MC_MULDIV_SIGNED_EN
//   defined   : op[1] selects signed MULT/DIV (abs on entry, sign fix-up on exit)
//   undefined : op[1] ignored, all ops unsigned, no abs/negate logic built
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        issue request, sampled only while o_busy==0
//   i_op           00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   i_src_a        multiplicand / dividend
//   i_src_b        multiplier / divisor
//   o_busy         operation in flight
//   o_done         one-cycle pulse, o_hi/o_lo valid from this cycle
//   o_div_by_zero  sticky flag for the last op, cleared on next accepted start
//   o_hi           MULT: product upper half; DIV: remainder
//   o_lo           MULT: product lower half; DIV: quotient
// ---------------------------------------------------------------------------
module mc_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned AW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_is_div, w_is_div_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_neg_res, w_neg_res_nxt;
  logic             r_neg_rem, w_neg_rem_nxt;
  // Multiply: {partial product, multiplier}. Divide: lower half is dividend/quotient.
  logic [AW-1:0]    r_acc, w_acc_nxt;
  // Working remainder for restoring division.
  logic [WIDTH:0]   r_rem, w_rem_nxt;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_dbz, w_dbz_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [AW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH+1:0] w_shift;
  logic             w_ge;

  // Operand conditioning on entry and sign fix-up on exit.
`ifdef MC_MULDIV_SIGNED_EN
  assign w_a_neg    = i_op[1] & i_src_a[WIDTH-1];
  assign w_b_neg    = i_op[1] & i_src_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (WIDTH'(0) - i_src_a) : i_src_a;
  assign w_b_mag    = w_b_neg ? (WIDTH'(0) - i_src_b) : i_src_b;
  assign w_prod_fix = r_neg_res ? (AW'(0) - r_acc) : r_acc;
  assign w_quo_fix  = r_neg_res ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? (WIDTH'(0) - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
`else
  logic [2:0] w_unused_sig;
  assign w_a_neg      = 1'b0;
  assign w_b_neg      = 1'b0;
  assign w_a_mag      = i_src_a;
  assign w_b_mag      = i_src_b;
  assign w_prod_fix   = r_acc;
  assign w_quo_fix    = r_acc[WIDTH-1:0];
  assign w_rem_fix    = r_rem[WIDTH-1:0];
  assign w_unused_sig = {i_op[1], r_neg_res, r_neg_rem};
`endif

  // Shift-add step: add multiplicand into the upper half when multiplier LSB is set.
  assign w_sum = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : WIDTH'(0))};

  // Restoring-subtract step: bring down the next dividend bit, MSB first.
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {2'b00, r_opnd});

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_is_div_nxt  = r_is_div;
    w_zero_nxt    = r_zero;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_acc_nxt     = r_acc;
    w_rem_nxt     = r_rem;
    w_opnd_nxt    = r_opnd;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_dbz_nxt     = r_dbz;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_busy_nxt    = 1'b1;
          w_dbz_nxt     = 1'b0;
          w_is_div_nxt  = i_op[0];
          w_neg_res_nxt = w_a_neg ^ w_b_neg;
          w_neg_rem_nxt = w_a_neg;
          w_rem_nxt     = '0;
          if (i_op[0] && (i_src_b == '0)) begin
            // Raw dividend is kept for HI; one wait cycle in FIX gives the two-cycle latency.
            w_state_nxt = S_FIX;
            w_zero_nxt  = 1'b1;
            w_count_nxt = CW'(1);
            w_acc_nxt   = {WIDTH'(0), i_src_a};
            w_opnd_nxt  = '0;
          end else begin
            w_state_nxt = S_RUN;
            w_zero_nxt  = 1'b0;
            w_count_nxt = '0;
            if (i_op[0]) begin
              w_acc_nxt  = {WIDTH'(0), w_a_mag};
              w_opnd_nxt = w_b_mag;
            end else begin
              w_acc_nxt  = {WIDTH'(0), w_b_mag};
              w_opnd_nxt = w_a_mag;
            end
          end
        end
      end

      S_RUN: begin
        if (r_is_div) begin
          w_rem_nxt = w_ge ? (WIDTH+1)'(w_shift - {2'b00, r_opnd}) : (WIDTH+1)'(w_shift);
          w_acc_nxt = {r_acc[AW-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
        end else begin
          w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end
        if (r_count == LAST) begin
          w_state_nxt = S_FIX;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end

      S_FIX: begin
        if (r_count != '0) begin
          w_count_nxt = r_count - CW'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          if (r_zero) begin
            w_hi_nxt  = r_acc[WIDTH-1:0];
            w_lo_nxt  = '1;
            w_dbz_nxt = 1'b1;
          end else if (r_is_div) begin
            w_hi_nxt = w_rem_fix;
            w_lo_nxt = w_quo_fix;
          end else begin
            w_hi_nxt = w_prod_fix[AW-1:WIDTH];
            w_lo_nxt = w_prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_is_div  <= 1'b0;
      r_zero    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_opnd    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_is_div  <= w_is_div_nxt;
      r_zero    <= w_zero_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_acc     <= w_acc_nxt;
      r_rem     <= w_rem_nxt;
      r_opnd    <= w_opnd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dbz     <= w_dbz_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mc_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_muldiv_unit
// Self-checking bench for mc_muldiv_unit at WIDTH=32: directed vector table,
// random ops against an arithmetic reference model, async reset mid-op.
// Follows MC_MULDIV_SIGNED_EN for the expected signedness of op[1].
// ---------------------------------------------------------------------------
module tb_mc_muldiv_unit;

  localparam int unsigned W = 32;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic [1:0]   i_op;
  logic [W-1:0] i_src_a;
  logic [W-1:0] i_src_b;
  logic         o_busy;
  logic         o_done;
  logic         o_div_by_zero;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;

  int n_chk = 0;
  int n_err = 0;

  mc_muldiv_unit #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_src_a       (i_src_a),
    .i_src_b       (i_src_b),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    bit           hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] hi, logic [W-1:0] lo, logic dbz, int lat, bit hold);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    v.dbz = dbz; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    bit          sg;
    longint      sa, sb, q, r;
    logic [63:0] t;
`ifdef MC_MULDIV_SIGNED_EN
    sg = op[1];
`else
    sg = 1'b0;
`endif
    dbz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[0]) begin
      if (sg) t = 64'(sa * sb);
      else    t = {32'b0, a} * {32'b0, b};
      hi = t[63:32];
      lo = t[31:0];
    end else if (b == '0) begin
      hi = a; lo = '1; dbz = 1'b1;
    end else if (sg) begin
      q = sa / sb;
      r = sa % sb;
      t = 64'(q); lo = t[31:0];
      t = 64'(r); hi = t[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Issues one op in the current cycle and waits (bounded) for its done pulse.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz, input int elat, input bit hold);
    int cyc;
    bit got;
    i_op = op; i_src_a = a; i_src_b = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    chk({nm, " busy_after_accept"}, W'(o_busy), W'(1));
    chk({nm, " dbz_cleared"}, W'(o_div_by_zero), W'(0));
    if (!hold) begin
      i_start = 1'b0;
      i_op    = 2'($urandom);
      i_src_a = $urandom;
      i_src_b = $urandom;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge i_clk); #1;
      cyc++;
      if (o_done) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, cyc);
    end else begin
      chk({nm, " latency"}, W'(cyc), W'(elat));
      chk({nm, " hi"}, o_hi, ehi);
      chk({nm, " lo"}, o_lo, elo);
      chk({nm, " dbz"}, W'(o_div_by_zero), W'(edbz));
      chk({nm, " busy_at_done"}, W'(o_busy), W'(0));
    end
    i_start = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b, ehi, elo;
    logic         edbz;
    bit           seen;

    i_rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_src_a = '0; i_src_b = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset busy", W'(o_busy), W'(0));
    chk("reset done", W'(o_done), W'(0));
    chk("reset dbz", W'(o_div_by_zero), W'(0));
    chk("reset hi", o_hi, W'(0));
    chk("reset lo", o_lo, W'(0));
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    vecs.push_back(mk("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0));
    vecs.push_back(mk("divu_100_7_hold", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1));
    vecs.push_back(mk("divu_5_0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, 1'b0));
    vecs.push_back(mk("divu_12_3", 2'b01, 32'd12, 32'd3, 32'd0, 32'd4, 1'b0, 33, 1'b0));
    vecs.push_back(mk("multu_msb_x2", 2'b00, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0, 33, 1'b0));
    vecs.push_back(mk("multu_zero", 2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 33, 1'b0));
    vecs.push_back(mk("divu_7_9", 2'b01, 32'd7, 32'd9, 32'd7, 32'd0, 1'b0, 33, 1'b0));
    vecs.push_back(mk("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 1'b0));
`ifdef MC_MULDIV_SIGNED_EN
    vecs.push_back(mk("mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 1'b0));
    vecs.push_back(mk("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0));
    vecs.push_back(mk("div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0));
    vecs.push_back(mk("div_m7_0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2, 1'b0));
`else
    vecs.push_back(mk("mult_as_multu", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 33, 1'b0));
    vecs.push_back(mk("div_as_divu", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 33, 1'b0));
`endif

    // Consecutive entries are issued in the done cycle of the previous op.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].dbz, vecs[i].lat, vecs[i].hold);
      if (vecs[i].hold) begin
        @(posedge i_clk); #1;
        chk({vecs[i].name, " no_second_done"}, W'(o_done), W'(0));
        chk({vecs[i].name, " idle_after"}, W'(o_busy), W'(0));
      end
    end

    // Random ops with random operand corruption after acceptance.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = {1'b1, 31'($urandom_range(0, 3))};
      model(op, a, b, ehi, elo, edbz);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ehi, elo, edbz,
             (op[0] && b == '0) ? 2 : 33, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge i_clk); #1;
      end
    end

    // Asynchronous reset while RUN is at count 10.
    i_op = 2'b00; i_src_a = 32'h1234_5678; i_src_b = 32'h9ABC_DEF0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    chk("midreset busy", W'(o_busy), W'(0));
    chk("midreset hi", o_hi, W'(0));
    chk("midreset lo", o_lo, W'(0));
    chk("midreset done", W'(o_done), W'(0));
    @(negedge i_clk) i_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) seen = 1'b1;
    end
    chk("midreset no_done_after_release", W'(seen), W'(0));
    chk("midreset hi_held", o_hi, W'(0));

    run_op("post_reset_multu", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
